// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline memory-access stage with data SRAM req/addr_ok/data_ok handshake
//
// Optional sub-word access support is enabled by defining MEM_SUBWORD_EN.
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   EX_to_MEM_valid, to_MEM_data, MEM_allow_in   EX->MEM handshake and bundle
//   WB_allow_in, MEM_to_WB_valid, to_WB_data     MEM->WB handshake and bundle
//   MEM_fwd                  {valid & gr_we, ready_go, dest} for ID hazard logic
//   data_sram_*              data SRAM request/response channel
module mem_stage #(
  parameter int TO_MEM_W = 75,
  parameter int TO_WB_W  = 38
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                EX_to_MEM_valid,
  input  logic [TO_MEM_W-1:0] to_MEM_data,
  output logic                MEM_allow_in,
  input  logic                WB_allow_in,
  output logic                MEM_to_WB_valid,
  output logic [TO_WB_W-1:0]  to_WB_data,
  output logic [6:0]          MEM_fwd,
  output logic                data_sram_req,
  output logic                data_sram_wr,
  output logic [1:0]          data_sram_size,
  output logic [3:0]          data_sram_wstrb,
  output logic [31:0]         data_sram_addr,
  output logic [31:0]         data_sram_wdata,
  input  logic                data_sram_addr_ok,
  input  logic                data_sram_data_ok,
  input  logic [31:0]         data_sram_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

  state_e                state_q, state_d;
  logic                  mem_valid_q, mem_valid_d;
  logic [TO_MEM_W-1:0]   bundle_q, bundle_d;
  logic [31:0]           rbuf_q, rbuf_d;

  logic [31:0] alu_result, rkd_value, final_result, raw_rdata, load_value;
  logic        mem_we, res_from_mem, gr_we, mem_acc, mem_ready_go, capture, cap_acc;
  logic [2:0]  mem_op;
  logic [4:0]  dest;
  state_e      after_done;

  assign alu_result   = bundle_q[74:43];
  assign rkd_value    = bundle_q[42:11];
  assign mem_we       = bundle_q[10];
  assign res_from_mem = bundle_q[9];
  assign mem_op       = bundle_q[8:6];
  assign dest         = bundle_q[5:1];
  assign gr_we        = bundle_q[0];

  assign mem_acc      = mem_we | res_from_mem;
  assign mem_ready_go = ~mem_acc | ((state_q == S_WAIT) & data_sram_data_ok) | (state_q == S_DONE);
  assign MEM_allow_in = ~mem_valid_q | (mem_ready_go & WB_allow_in);
  assign MEM_to_WB_valid = mem_valid_q & mem_ready_go;
  assign capture      = EX_to_MEM_valid & MEM_allow_in;
  assign cap_acc      = to_MEM_data[10] | to_MEM_data[9];
  // A finishing access hands straight over to the next one if it is captured now.
  assign after_done   = (capture & cap_acc) ? S_REQ : S_IDLE;

  always_comb begin
    mem_valid_d = MEM_allow_in ? EX_to_MEM_valid : mem_valid_q;
    bundle_d    = capture ? to_MEM_data : bundle_q;
    rbuf_d      = rbuf_q;
    state_d     = state_q;
    case (state_q)
      S_IDLE: if (capture && cap_acc) state_d = S_REQ;
      S_REQ:  if (data_sram_addr_ok) state_d = S_WAIT;
      S_WAIT: begin
        if (data_sram_data_ok) begin
          if (WB_allow_in) begin
            state_d = after_done;
          end else begin
            state_d = S_DONE;
            rbuf_d  = data_sram_rdata;
          end
        end
      end
      S_DONE: if (WB_allow_in) state_d = after_done;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      mem_valid_q <= 1'b0;
      bundle_q    <= '0;
      rbuf_q      <= '0;
    end else begin
      state_q     <= state_d;
      mem_valid_q <= mem_valid_d;
      bundle_q    <= bundle_d;
      rbuf_q      <= rbuf_d;
    end
  end

  assign data_sram_req  = mem_valid_q & (state_q == S_REQ);
  assign data_sram_wr   = mem_we;
  assign data_sram_addr = alu_result;
  // In DONE the SRAM has already returned its data, so use the buffered copy.
  assign raw_rdata      = (state_q == S_DONE) ? rbuf_q : data_sram_rdata;

`ifdef MEM_SUBWORD_EN
  logic [31:0] byte_lane, half_lane;
  logic [3:0]  strb;

  assign byte_lane = raw_rdata >> {alu_result[1:0], 3'b000};
  assign half_lane = raw_rdata >> {alu_result[1], 4'b0000};

  always_comb begin
    data_sram_size  = 2'd2;
    strb            = 4'hf;
    data_sram_wdata = rkd_value;
    load_value      = raw_rdata;
    case (mem_op)
      3'b001, 3'b010: begin
        data_sram_size  = 2'd0;
        strb            = 4'b0001 << alu_result[1:0];
        data_sram_wdata = {4{rkd_value[7:0]}};
        load_value      = (mem_op == 3'b001) ? {{24{byte_lane[7]}}, byte_lane[7:0]}
                                             : {24'd0, byte_lane[7:0]};
      end
      3'b011, 3'b100: begin
        data_sram_size  = 2'd1;
        strb            = 4'b0011 << {alu_result[1], 1'b0};
        data_sram_wdata = {2{rkd_value[15:0]}};
        load_value      = (mem_op == 3'b011) ? {{16{half_lane[15]}}, half_lane[15:0]}
                                             : {16'd0, half_lane[15:0]};
      end
      default: ;
    endcase
    data_sram_wstrb = mem_we ? strb : 4'h0;
  end
`else
  logic unused_mem_op;
  assign unused_mem_op   = ^mem_op;
  assign data_sram_size  = 2'd2;
  assign data_sram_wstrb = mem_we ? 4'hf : 4'h0;
  assign data_sram_wdata = rkd_value;
  assign load_value      = raw_rdata;
`endif

  assign final_result = res_from_mem ? load_value : alu_result;
  assign to_WB_data   = {final_result, dest, gr_we};
  assign MEM_fwd      = {mem_valid_q & gr_we, mem_ready_go, dest};

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - randomized self-checking bench for mem_stage against a transaction-level slot model
module tb_mem_stage;

  localparam int FAST_END = 500;
  localparam int RAND_END = 1800;
  localparam int N_CYC    = 3000;

  logic        clk = 1'b0;
  logic        reset;
  logic        EX_to_MEM_valid;
  logic [74:0] to_MEM_data;
  logic        MEM_allow_in;
  logic        WB_allow_in;
  logic        MEM_to_WB_valid;
  logic [37:0] to_WB_data;
  logic [6:0]  MEM_fwd;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;
  logic        data_sram_addr_ok, data_sram_data_ok;

  mem_stage dut (
    .clk(clk), .reset(reset),
    .EX_to_MEM_valid(EX_to_MEM_valid), .to_MEM_data(to_MEM_data), .MEM_allow_in(MEM_allow_in),
    .WB_allow_in(WB_allow_in), .MEM_to_WB_valid(MEM_to_WB_valid), .to_WB_data(to_WB_data),
    .MEM_fwd(MEM_fwd),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
    .data_sram_wstrb(data_sram_wstrb), .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [74:0] mk(input logic [31:0] alu, input logic [31:0] rkd, input logic we,
                                     input logic rfm, input logic [2:0] op, input logic [4:0] dst,
                                     input logic gr);
    return {alu, rkd, we, rfm, op, dst, gr};
  endfunction

  // Expected SRAM request fields and load result, from the access-size rules.
  function automatic logic [1:0] exp_size(input logic [2:0] op);
`ifdef MEM_SUBWORD_EN
    if (op == 3'd1 || op == 3'd2) return 2'd0;
    if (op == 3'd3 || op == 3'd4) return 2'd1;
`endif
    return 2'd2;
  endfunction

  function automatic logic [3:0] exp_wstrb(input logic we, input logic [2:0] op, input logic [1:0] a);
    if (!we) return 4'h0;
`ifdef MEM_SUBWORD_EN
    if (exp_size(op) == 2'd0) return 4'(1 << a);
    if (exp_size(op) == 2'd1) return a[1] ? 4'b1100 : 4'b0011;
`endif
    return 4'hf;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] op, input logic [31:0] rkd);
`ifdef MEM_SUBWORD_EN
    if (exp_size(op) == 2'd0) return rkd[7:0] * 32'h01010101;
    if (exp_size(op) == 2'd1) return rkd[15:0] * 32'h00010001;
`endif
    return rkd;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] op, input logic [1:0] a, input logic [31:0] rd);
`ifdef MEM_SUBWORD_EN
    logic [7:0]  b;
    logic [15:0] h;
    b = rd[8*a +: 8];
    h = rd[16*a[1] +: 16];
    case (op)
      3'd1: return (b >= 8'h80) ? 32'(b) - 32'h100 : 32'(b);
      3'd2: return 32'(b);
      3'd3: return (h >= 16'h8000) ? 32'(h) - 32'h10000 : 32'(h);
      3'd4: return 32'(h);
      default: return rd;
    endcase
`else
    return rd;
`endif
  endfunction

  logic [74:0] dir_tab [$];
  logic [74:0] slot;
  logic        slot_v, slot_req_done, slot_got, slot_acc;
  logic [31:0] slot_rd, rd, res;
  logic        outst, exp_ready, exp_allow, ex_taken, data_now, reset_done;
  int          cnt, cap_cyc, n_done;

  initial begin
    dir_tab.push_back(mk(32'h0000_1234, 32'h0, 1'b0, 1'b0, 3'd0, 5'd5, 1'b1));
    dir_tab.push_back(mk(32'h0000_0100, 32'h0, 1'b0, 1'b1, 3'd0, 5'd3, 1'b1));
    dir_tab.push_back(mk(32'h0000_0200, 32'hA5A5A5A5, 1'b1, 1'b0, 3'd0, 5'd0, 1'b0));
`ifdef MEM_SUBWORD_EN
    dir_tab.push_back(mk(32'h0000_0203, 32'h0, 1'b0, 1'b1, 3'd1, 5'd7, 1'b1));
    dir_tab.push_back(mk(32'h0000_0202, 32'h1234, 1'b1, 1'b0, 3'd3, 5'd0, 1'b0));
`endif
    reset = 1'b1; EX_to_MEM_valid = 1'b0; to_MEM_data = '0; WB_allow_in = 1'b0;
    data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0; data_sram_rdata = '0;
    slot = '0; slot_v = 0; slot_req_done = 0; slot_got = 0; slot_rd = '0;
    outst = 0; cnt = 0; cap_cyc = 0; n_done = 0; ex_taken = 1; reset_done = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_allow", MEM_allow_in, 1'b1);
    check("rst_wb_valid", MEM_to_WB_valid, 1'b0);
    check("rst_req", data_sram_req, 1'b0);
    check("rst_fwd_v", MEM_fwd[6], 1'b0);

    for (int cyc = 0; cyc < N_CYC; cyc++) begin
      @(posedge clk); #1;
      slot_acc = slot[10] | slot[9];
      // Drop an in-flight memory instruction with a mid-transaction reset.
      if (!reset_done && cyc > 1200 && slot_v && slot_acc) begin
        reset = 1'b1; EX_to_MEM_valid = 1'b0;
        data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0; reset_done = 1;
        slot_v = 0; outst = 0; ex_taken = 1;
      end
      // EX side: hold the bundle until it is taken.
      if (!EX_to_MEM_valid || ex_taken) begin
        if (dir_tab.size() > 0) begin
          EX_to_MEM_valid = 1'b1;
          to_MEM_data = dir_tab.pop_front();
        end else begin
          int k;
          k = $urandom_range(2);
          EX_to_MEM_valid = (cyc < FAST_END) ? 1'b1 : ($urandom_range(3) != 0);
          to_MEM_data = mk($urandom, $urandom, k == 2, k == 1, 3'($urandom_range(4)),
                           5'($urandom), 1'($urandom));
        end
      end
      if (cyc < FAST_END)      WB_allow_in = 1'b1;
      else if (cyc < RAND_END) WB_allow_in = ($urandom_range(3) != 0);
      else                     WB_allow_in = ($urandom_range(2) == 0);
      // SRAM side.
      data_sram_addr_ok = data_sram_req && ((cyc < FAST_END) || ($urandom_range(2) == 0));
      data_sram_data_ok = outst && (cnt == 0);
      if (data_sram_data_ok && slot[74:43] == 32'h100)      data_sram_rdata = 32'hDEADBEEF;
      else if (data_sram_data_ok && slot[74:43] == 32'h203) data_sram_rdata = 32'h80FF_FFFF;
      else                                                  data_sram_rdata = $urandom;

      @(negedge clk);
      slot_acc  = slot[10] | slot[9];
      data_now  = data_sram_data_ok;
      exp_ready = slot_v && (!slot_acc || slot_got || data_now);
      exp_allow = !slot_v || (exp_ready && WB_allow_in);
      check("allow_in", MEM_allow_in, exp_allow);
      check("wb_valid", MEM_to_WB_valid, exp_ready);
      check("req", data_sram_req, slot_v && slot_acc && !slot_req_done);
      check("fwd_v", MEM_fwd[6], slot_v & slot[0]);
      if (slot_v) check("fwd_rdy_dest", MEM_fwd[5:0], {exp_ready, slot[5:1]});
      if (slot_v && slot_acc && !slot_req_done) begin
        check("sram_addr", data_sram_addr, slot[74:43]);
        check("sram_wr", data_sram_wr, slot[10]);
        check("sram_size", data_sram_size, exp_size(slot[8:6]));
        check("sram_wstrb", data_sram_wstrb, exp_wstrb(slot[10], slot[8:6], slot[44:43]));
        if (slot[10]) check("sram_wdata", data_sram_wdata, exp_wdata(slot[8:6], slot[42:11]));
      end
      if (exp_ready) begin
        rd  = data_now ? data_sram_rdata : slot_rd;
        res = slot[9] ? exp_load(slot[8:6], slot[44:43], rd) : slot[74:43];
        check("wb_data", to_WB_data, {res, slot[5:1], slot[0]});
        if (WB_allow_in) begin
          n_done++;
          if (cyc < FAST_END) check("latency", 64'(cyc - cap_cyc), slot_acc ? 64'd2 : 64'd1);
        end
      end
      // Model state update for the coming edge.
      if (data_now) begin
        slot_got = 1; slot_rd = data_sram_rdata; outst = 0;
      end else if (outst && cnt > 0) begin
        cnt--;
      end
      if (data_sram_req && data_sram_addr_ok) begin
        outst = 1; slot_req_done = 1;
        cnt = (cyc < FAST_END) ? 0 : $urandom_range(2);
      end
      ex_taken = EX_to_MEM_valid && exp_allow;
      if (exp_allow) begin
        slot_v = EX_to_MEM_valid; slot = to_MEM_data;
        slot_req_done = 0; slot_got = 0; cap_cyc = cyc;
      end
    end
    check("completions_seen", 64'(n_done > 200), 64'd1);
    check("mid_reset_seen", 64'(reset_done), 64'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
